// File: rtl/port_bcd_converter_pkg.sv
// Shared encodings and sizes for the display-port BCD converter and its
// double-dabble step.
package port_bcd_converter_pkg;

    localparam int NUM_CH      = 3;
    localparam int IN_W        = 8;
    localparam int BCD_W       = 12;
    localparam int SHIFT_ITERS = 8;
    localparam int SR_W        = BCD_W + IN_W;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STORE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/dd_step.sv
// One double-dabble iteration on a 20-bit {bcd[11:0], bin[7:0]} word:
// add 3 to every BCD nibble that is >= 5, then shift left by one.
module dd_step
    import port_bcd_converter_pkg::*;
(
    input  logic [SR_W-1:0] din,
    output logic [SR_W-1:0] dout
);

    logic [SR_W-1:0] adj;

    assign adj[IN_W-1:0] = din[IN_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < BCD_W / 4; gi++) begin : g_nib
            logic [3:0] nib;
            assign nib = din[IN_W + 4*gi +: 4];
            assign adj[IN_W + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate

    assign dout = adj << 1;

endmodule

// File: rtl/port_bcd_converter.sv
// Round-robin binary-to-BCD converter for three 8-bit display ports sharing
// one double-dabble engine; each channel's digits update atomically.
module port_bcd_converter
    import port_bcd_converter_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   port0,
    input  logic [IN_W-1:0]   port1,
    input  logic [IN_W-1:0]   port2,
    output logic [BCD_W-1:0]  bcd0,
    output logic [BCD_W-1:0]  bcd1,
    output logic [BCD_W-1:0]  bcd2,
    output logic              valid,
    output logic              sweep_done
);

    localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0]  IT_LAST  = 3'(SHIFT_ITERS - 1);
    localparam logic [1:0]  CH_LAST  = 2'(NUM_CH - 1);

    state_t            state_reg, state_next;
    logic [SR_W-1:0]   sr_reg;
    logic [SR_W-1:0]   sr_step;
    logic [2:0]        it_reg;
    logic [1:0]        ch_reg;
    logic [15:0]       gap_cnt_reg;
    logic              valid_reg;
    logic              sweep_done_reg;
    logic [IN_W-1:0]   port_sel;
    logic [BCD_W-1:0]  bcd_reg [NUM_CH];

    always_comb begin
        port_sel = port2;
        case (ch_reg)
            2'd0:    port_sel = port0;
            2'd1:    port_sel = port1;
            default: port_sel = port2;
        endcase
    end

    dd_step u_dd_step (
        .din  (sr_reg),
        .dout (sr_step)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: if (it_reg == IT_LAST) state_next = ST_STORE;
            ST_STORE: begin
                if (ch_reg == CH_LAST)
                    state_next = (GAP_CYCLES > 0) ? ST_GAP : ST_LOAD;
                else
                    state_next = ST_LOAD;
            end
            ST_GAP:   if (gap_cnt_reg == GAP_LAST) state_next = ST_LOAD;
            default:  state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_LOAD;
            sr_reg         <= '0;
            it_reg         <= '0;
            ch_reg         <= '0;
            gap_cnt_reg    <= '0;
            valid_reg      <= 1'b0;
            sweep_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sweep_done_reg <= 1'b0;
            case (state_reg)
                ST_LOAD: begin
                    sr_reg <= {{(SR_W - IN_W){1'b0}}, port_sel};
                    it_reg <= '0;
                end
                ST_SHIFT: begin
                    sr_reg <= sr_step;
                    it_reg <= it_reg + 3'd1;
                end
                ST_STORE: begin
                    gap_cnt_reg <= '0;
                    if (ch_reg == CH_LAST) begin
                        ch_reg         <= '0;
                        valid_reg      <= 1'b1;
                        sweep_done_reg <= 1'b1;
                    end else begin
                        ch_reg <= ch_reg + 2'd1;
                    end
                end
                ST_GAP: gap_cnt_reg <= gap_cnt_reg + 16'd1;
                default: ;
            endcase
        end
    end

    // Each channel's digits get their own register bank, written only in
    // that channel's STORE cycle so the other two hold steady.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_bcd
            always_ff @(posedge clk) begin
                if (rst)
                    bcd_reg[gi] <= '0;
                else if (state_reg == ST_STORE && ch_reg == 2'(gi))
                    bcd_reg[gi] <= sr_reg[SR_W-1:IN_W];
            end
        end
    endgenerate

    assign bcd0       = bcd_reg[0];
    assign bcd1       = bcd_reg[1];
    assign bcd2       = bcd_reg[2];
    assign valid      = valid_reg;
    assign sweep_done = sweep_done_reg;

endmodule

// File: tb/tb_port_bcd_converter.sv
// Bench for port_bcd_converter: two instances (no gap / 5-cycle gap) against a
// schedule-and-decimal model, plus literal checks and an exhaustive dd_step sweep.
module tb_port_bcd_converter;

    localparam int GAP_B = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  p0 = 8'd0, p1 = 8'd9, p2 = 8'd255;
    logic [11:0] bcd_o [2][3];
    logic        valid_o [2];
    logic        sd_o [2];
    logic [19:0] dd_in = '0;
    logic [19:0] dd_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    port_bcd_converter #(.GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .rst(rst), .port0(p0), .port1(p1), .port2(p2),
        .bcd0(bcd_o[0][0]), .bcd1(bcd_o[0][1]), .bcd2(bcd_o[0][2]),
        .valid(valid_o[0]), .sweep_done(sd_o[0])
    );

    port_bcd_converter #(.GAP_CYCLES(GAP_B)) dut_g5 (
        .clk(clk), .rst(rst), .port0(p0), .port1(p1), .port2(p2),
        .bcd0(bcd_o[1][0]), .bcd1(bcd_o[1][1]), .bcd2(bcd_o[1][2]),
        .valid(valid_o[1]), .sweep_done(sd_o[1])
    );

    dd_step u_dd (.din(dd_in), .dout(dd_out));

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : GAP_B;
    endfunction

    function automatic logic [7:0] port_val(input int c);
        return (c == 0) ? p0 : (c == 1) ? p1 : p2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each instance runs a fixed schedule of 10-cycle channel slots
    // followed by its gap; the value seen at a slot's first edge is what that
    // channel shows (in decimal digits) after the slot's last edge.
    int          k_m [2];
    logic [7:0]  lat_m [2][3];
    logic [11:0] exp_bcd [2][3];
    logic        exp_valid [2];
    logic        exp_sd [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            k_m[i] = 0; exp_valid[i] = 1'b0; exp_sd[i] = 1'b0;
            for (int j = 0; j < 3; j++) begin
                exp_bcd[i][j] = '0; lat_m[i][j] = '0;
            end
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    k_m[i] = 0; exp_valid[i] = 1'b0; exp_sd[i] = 1'b0;
                    for (int j = 0; j < 3; j++) exp_bcd[i][j] = '0;
                end else begin
                    int p;
                    int c;
                    k_m[i]++;
                    p = (k_m[i] - 1) % (30 + gap_of(i));
                    exp_sd[i] = 1'b0;
                    if (p < 30) begin
                        c = p / 10;
                        if (p % 10 == 0) lat_m[i][c] = port_val(c);
                        if (p % 10 == 9) begin
                            exp_bcd[i][c] = to_bcd(int'(lat_m[i][c]));
                            if (c == 2) begin
                                exp_valid[i] = 1'b1;
                                exp_sd[i]    = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Compare every cycle, and track the spacing between sweep_done pulses.
    int cyc = 0;
    int last_sd [2] = '{-1, -1};
    int sd_cnt [2] = '{0, 0};

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 3; j++)
                    chk($sformatf("g%0d_bcd%0d", gap_of(i), j), 32'(bcd_o[i][j]), 32'(exp_bcd[i][j]));
                chk($sformatf("g%0d_valid", gap_of(i)), 32'(valid_o[i]), 32'(exp_valid[i]));
                chk($sformatf("g%0d_sweep_done", gap_of(i)), 32'(sd_o[i]), 32'(exp_sd[i]));
                if (k_m[i] == 0) begin
                    last_sd[i] = -1;
                end else if (sd_o[i] === 1'b1) begin
                    sd_cnt[i]++;
                    if (last_sd[i] >= 0)
                        chk($sformatf("g%0d_sd_spacing", gap_of(i)), 32'(cyc - last_sd[i]), 32'(30 + gap_of(i)));
                    last_sd[i] = cyc;
                end
            end
        end
    end

    initial begin
        logic [19:0] w;
        int guard;

        // dd_step: eight chained steps must yield the decimal digits.
        for (int v = 0; v < 256; v++) begin
            w = {12'h000, 8'(v)};
            for (int s = 0; s < 8; s++) begin
                dd_in = w;
                #1;
                w = dd_out;
            end
            chk($sformatf("dd_step_%0d", v), 32'(w[19:8]), 32'(to_bcd(v)));
            if (v == 100) chk("dd_step_lit_100", 32'(w[19:8]), 32'h100);
            if (v == 128) chk("dd_step_lit_128", 32'(w[19:8]), 32'h128);
            if (v == 250) chk("dd_step_lit_250", 32'(w[19:8]), 32'h250);
        end

        // Reset state, then the first sweep with 0 / 9 / 255.
        repeat (2) @(negedge clk);
        chk("rst_bcd0", 32'(bcd_o[0][0]), 32'h000);
        chk("rst_valid", 32'(valid_o[0]), 32'd0);
        chk("rst_sweep_done", 32'(sd_o[0]), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("c10_bcd0", 32'(bcd_o[0][0]), 32'h000);
        chk("c10_valid", 32'(valid_o[0]), 32'd0);
        repeat (10) @(negedge clk);
        chk("c20_bcd1", 32'(bcd_o[0][1]), 32'h009);
        chk("c20_bcd2_unset", 32'(bcd_o[0][2]), 32'h000);
        repeat (10) @(negedge clk);
        chk("c31_bcd2", 32'(bcd_o[0][2]), 32'h255);
        chk("c31_valid", 32'(valid_o[0]), 32'd1);
        chk("c31_sweep_done", 32'(sd_o[0]), 32'd1);
        chk("c31_g5_bcd2", 32'(bcd_o[1][2]), 32'h255);
        @(negedge clk);
        chk("c32_sweep_done", 32'(sd_o[0]), 32'd0);

        // Randomised port activity; the model checks every cycle.
        repeat (150) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) p0 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) p1 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) p2 = 8'($urandom);
        end

        // 199 sampled at channel 0's LOAD, 42 arrives mid-conversion.
        guard = 0;
        while (k_m[0] % 30 != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("align_timeout", 32'(guard < 40), 32'd1);
        p0 = 8'd199;
        repeat (3) @(negedge clk);
        p0 = 8'd42;
        repeat (7) @(negedge clk);
        chk("bcd0_199", 32'(bcd_o[0][0]), 32'h199);
        repeat (30) @(negedge clk);
        chk("bcd0_042", 32'(bcd_o[0][0]), 32'h042);

        // Reset at cycle 25, then a clean restart.
        p0 = 8'd7; p1 = 8'd128; p2 = 8'd250;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (24) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_bcd0", 32'(bcd_o[0][0]), 32'h000);
        chk("mid_rst_bcd1", 32'(bcd_o[0][1]), 32'h000);
        chk("mid_rst_valid", 32'(valid_o[0]), 32'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("restart_bcd0", 32'(bcd_o[0][0]), 32'h007);
        chk("restart_bcd1", 32'(bcd_o[0][1]), 32'h128);
        chk("restart_bcd2", 32'(bcd_o[0][2]), 32'h250);
        chk("restart_valid", 32'(valid_o[0]), 32'd1);

        // Constant inputs: gap instance keeps pulsing every 35 cycles.
        sd_cnt[1] = 0;
        repeat (120) @(negedge clk);
        chk("g5_pulse_count", 32'(sd_cnt[1] >= 3), 32'd1);
        chk("g5_hold_bcd1", 32'(bcd_o[1][1]), 32'h128);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
